// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver for the debug/host serial link. It is the receive-side
//   partner of uart_tx. The serial pin is synchronised first. The bit period
//   is set at runtime by a divisor, and each completed byte is placed in a
//   one-entry valid/ready holding register for the system-side consumer.
//   Framing and overrun errors are reported as single-cycle pulses.
//
// Parameters
//   DIV_W      width of the bit-period divisor input
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   divisor    clk cycles per bit; values below 4 are treated as 4
//   rx_i       serial line, asynchronous, idles high
//   rx_data    received byte, stable while rx_valid=1
//   rx_valid   holding register contains a byte
//   rx_ready   consumer accepts the byte when rx_valid=1
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: completed byte dropped, holding register full
//   busy       receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] divisor,
  input  logic             rx_i,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(4);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  // Two-flop synchroniser. Both stages reset to the idle (high) level, so a
  // reset release never looks like a start bit.
  logic syncA_q;
  logic rxS_q;

  // Receiver state and datapath.
  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] bitCnt_q;
  logic [2:0]       bitIdx_q;
  logic [7:0]       shift_q;
  logic             busy_q;

  // Holding register and status pulses.
  logic [7:0] rxData_q;
  logic       rxValid_q;
  logic       frameErr_q;
  logic       overrun_q;

  // Combinational helpers.
  logic [DIV_W-1:0] divClamp;
  logic             sampleNow;
  logic             deliver_d;
  logic             frameErr_d;
  logic             take;

  // Clamp the divisor. Smaller values would leave too few cycles per bit for
  // the half-period start alignment.
  assign divClamp  = (divisor < MIN_DIV) ? MIN_DIV : divisor;
  assign sampleNow = (bitCnt_q == '0);

  // A stop-bit sample decides the fate of the assembled byte.
  assign deliver_d  = (state_q == STOP) && sampleNow && rxS_q;
  assign frameErr_d = (state_q == STOP) && sampleNow && !rxS_q;
  assign take       = rxValid_q && rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncA_q <= 1'b1;
      rxS_q   <= 1'b1;
    end else begin
      syncA_q <= rx_i;
      rxS_q   <= syncA_q;
    end
  end

  // Receive FSM. The divisor is captured at start detection, so changes made
  // mid-frame only take effect on the next frame. The counter loaded with N
  // reaches zero N+1 cycles later, and that cycle is the sample point.
  // Loading (D>>1)-1 puts the start-bit sample at mid-bit. Reloading D-1
  // puts each following sample one full bit period later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= MIN_DIV;
      bitCnt_q <= '0;
      bitIdx_q <= 3'd0;
      shift_q  <= 8'd0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!rxS_q) begin
            state_q  <= START;
            div_q    <= divClamp;
            bitCnt_q <= (divClamp >> 1) - ONE;
            busy_q   <= 1'b1;
          end
        end

        START: begin
          if (sampleNow) begin
            if (!rxS_q) begin
              state_q  <= DATA;
              bitCnt_q <= div_q - ONE;
              bitIdx_q <= 3'd0;
            end else begin
              // A low pulse shorter than half a bit is treated as line noise.
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            bitCnt_q <= bitCnt_q - ONE;
          end
        end

        DATA: begin
          if (sampleNow) begin
            // LSB arrives first, so shift right and insert at the top.
            shift_q  <= {rxS_q, shift_q[7:1]};
            bitCnt_q <= div_q - ONE;
            bitIdx_q <= bitIdx_q + 3'd1;
            if (bitIdx_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            bitCnt_q <= bitCnt_q - ONE;
          end
        end

        STOP: begin
          if (sampleNow) begin
            if (rxS_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= WAIT_HIGH;
            end
          end else begin
            bitCnt_q <= bitCnt_q - ONE;
          end
        end

        WAIT_HIGH: begin
          // Hold off while the line stays low, so that a break condition is
          // reported once and is not decoded as a run of zero frames.
          if (rxS_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Holding register. A delivery that coincides with a transfer refills the
  // register in the same cycle, so rx_valid stays high. A delivery into a
  // full register that is not being drained drops the new byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxData_q   <= 8'd0;
      rxValid_q  <= 1'b0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      frameErr_q <= frameErr_d;
      overrun_q  <= 1'b0;
      if (deliver_d) begin
        if (!rxValid_q || take) begin
          rxData_q  <= shift_q;
          rxValid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (take) begin
        rxValid_q <= 1'b0;
      end
    end
  end

  assign rx_data   = rxData_q;
  assign rx_valid  = rxValid_q;
  assign frame_err = frameErr_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule
